// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed seven-segment scan driver with frame-atomic value loading
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module seg7_scan #(
    parameter int DIGITS     = 4,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic sync1_q, sync2_q, hist_q;
    logic tick, boundary, hs;
    logic [IW-1:0] idx_q, idx_d;
    logic [0:0] state_q, state_d;
    logic ready_q;
    logic [4*DIGITS-1:0] pend_val_q, disp_val_q, disp_val_d;
    logic [DIGITS-1:0] pend_dp_q, disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic dp_q, dp_d;
    logic [3:0] nib;
    logic blank;

    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign tick     = sync2_q & ~hist_q;
    assign boundary = tick && (idx_q == IW'(DIGITS - 1));
    assign hs       = load_valid & ready_q;

    always_comb begin
        idx_d = idx_q;
        if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

        state_d = state_q;
        case (state_q)
            S_EMPTY: if (hs) state_d = S_FULL;
            default: if (boundary) state_d = S_EMPTY;
        endcase

        // The commit and the first digit of the new frame happen on the same edge.
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (state_q == S_FULL && boundary) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
        end

        nib   = disp_val_d[idx_d*4 +: 4];
        blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            logic [IW-1:0] top;
            top = '0;
            for (int k = 0; k < DIGITS; k++)
                if (disp_val_d[4*k +: 4] != 4'h0) top = IW'(k);
            blank = (idx_d > top);
        end
`endif
        an_d  = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
        seg_d = blank ? 7'h00 : hex_decode(nib);
        dp_d  = disp_dp_d[idx_d];
        if (ACTIVE_LOW) begin
            an_d  = ~an_d;
            seg_d = ~seg_d;
            dp_d  = ~dp_d;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            idx_q      <= '0;
            state_q    <= S_EMPTY;
            ready_q    <= 1'b0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            an_q       <= ACTIVE_LOW ? '1 : '0;
            seg_q      <= ACTIVE_LOW ? 7'h7F : 7'h00;
            dp_q       <= ACTIVE_LOW;
        end else begin
            sync1_q    <= scan_clk;
            sync2_q    <= sync1_q;
            hist_q     <= sync2_q;
            idx_q      <= idx_d;
            state_q    <= state_d;
            ready_q    <= (state_d == S_EMPTY);
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            if (hs) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
            end
            if (tick) begin
                an_q  <= an_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
            end
        end
    end

    assign load_ready = ready_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed seven-segment display driver for the Basys 3 four-digit display. It sits directly downstream of the clock divider and consumes one of its divided clock outputs as a scan rate, for example 1 kHz. It brings that clock into the `sysclk` domain as a single-cycle tick, scans one digit per tick, and decodes hex nibbles to segments. It accepts new display values through a valid/ready handshake and commits them only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
Parameters:
- `DIGITS`, default 4: number of multiplexed digits; value width is 4*`DIGITS`.
- `ACTIVE_LOW`, default 1: 1 means anodes, segments and dp are driven active-low (Basys 3); 0 means active-high.

Ports:
- `sysclk`  in  1  system clock, 100 MHz; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `scan_clk`  in  1  divided clock from the clock divider, sampled as data, never used as a clock.
- `value`  in  4*`DIGITS`  hex value; nibble k drives digit k, digit 0 is rightmost.
- `dp_in`  in  `DIGITS`  decimal-point enables, one per digit.
- `load_valid`  in  1  `value`/`dp_in` offered.
- `load_ready`  out  1  pending buffer empty; transfer occurs when `load_valid` and `load_ready` are both high.
- `an`  out  `DIGITS`  digit anode enables.
- `seg`  out  7  segments {g,f,e,d,c,b,a}.
- `dp`  out  1  decimal-point segment.

## Operation
- **Tick generation:** `scan_clk` passes through two synchronizer flops plus one history flop. `tick` = sync2 & ~hist, i.e. one `sysclk` cycle per `scan_clk` rising edge.
- **Digit index:** `idx` counts 0..`DIGITS`-1 and advances on `tick`. It wraps from `DIGITS`-1 to 0; that wrap tick is the frame boundary.
- **Pending buffer:** a two-state FSM with states EMPTY and FULL.
  - EMPTY→FULL on a handshake; captures `value` and `dp_in`.
  - FULL→EMPTY on a frame-boundary tick; copies pending into the display register.
  - `load_ready` = (state==EMPTY), registered.
  - No handshake can occur while FULL. A handshake in EMPTY on a frame-boundary cycle is captured, and the commit waits for the next boundary.
- **Output stage:** registered, updated on `tick` only.
  - `an` is one-hot of the new `idx`.
  - `seg` is the hex decode of display nibble[new `idx`].
  - `dp` = display dp[new `idx`].
  - All outputs are inverted when `ACTIVE_LOW`=1.
  - Between ticks, outputs hold their values.
- **Decode (active-high):** 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71.
- **Commit visibility:** a value committed at a frame boundary is shown starting at digit 0 of that same tick's output update.

## Timing
- **Reset values:**
  - `idx`=0, display register=0, dp register=0, FSM=EMPTY.
  - `load_ready`=0 during reset, 1 on the first cycle after `rst` falls.
  - `an`, `seg`, `dp` are all off (all ones when `ACTIVE_LOW`=1).
- **Outputs after reset:** remain blank until the first tick after reset.
- **Latency:**
  - `scan_clk` rise to `tick`: 3 `sysclk` cycles.
  - `tick` to `an`/`seg`/`dp` change: 1 cycle.
  - Handshake to `load_ready` low: 1 cycle.
  - Frame-boundary tick to `load_ready` high: 1 cycle.
- **`scan_clk` requirement:** high and low phases of at least 2 `sysclk` cycles each. Faster inputs are out of contract.
- **Reset mid-operation:** `rst` abandons any pending value, clears the display register and blanks all outputs in the next cycle. A `load_valid` asserted during reset is ignored.
- **Input stability:** `value` and `dp_in` are sampled only in the handshake cycle and may change freely afterwards.

## Configuration
- **`SEG7_LEADING_ZERO_BLANK_EN` defined:** digits more significant than the highest nonzero nibble are blanked (segments off). Digit 0 is always shown, and `dp` still follows the dp register. Example: value 0x0042 shows "  42"; 0x0000 shows "   0".
- **`SEG7_LEADING_ZERO_BLANK_EN` undefined:** every digit always shows its nibble. Example: 0x0042 shows "0042".

## Test plan
- **Reset:** hold `rst` high for 5 cycles with `scan_clk` toggling → `an`=4'hF, `seg`=7'h7F, `dp`=1 (`ACTIVE_LOW`=1); `load_ready`=0 during reset and 1 on the cycle after release.
- **Scan order:** load 0x1234, then run `scan_clk` with a period of 20 `sysclk` → after commit, `an` cycles E,D,B,7 with `seg` cycling ~06(4→~66 at idx 0)…; concretely, the idx0 cycle shows `an`=4'hE, `seg`=~7'h66, and the next tick shows `an`=4'hD, `seg`=~7'h4F. Each change lands 1 cycle after `tick`, 4 cycles after the `scan_clk` rise.
- **Frame atomicity:** display 0x1111, load 0x2222 while idx=1 → digits 2 and 3 of the current frame still show 1; `load_ready` stays 0 until the boundary tick+1; the next frame shows 2 on all digits.
- **Backpressure:** hold `load_valid`=1 with changing `value` while FULL → no capture; the value present on the first cycle `load_ready`=1 is the one captured.
- **Reset mid-frame:** assert `rst` while FULL and at idx=2 → the next cycle is blank with idx=0; the pending value is never displayed.
- **Leading zeros:** value 0x0042, dp_in=4'b0100 → with the macro, digits 3 and 2 are blank and digit 2 shows only dp; without the macro, digits 3 and 2 show `seg`=~7'h3F.
